// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//
// Purpose: shared constants for the shift_reg delay line and its stage cell.
//          The word width is a parameter of each module, so it is not fixed
//          here. Only the default geometry lives in this package.
//
// Contents:
//   DEFAULT_N  default word width in bits
//   DEFAULT_M  default number of stages (delay in clock cycles)
// -----------------------------------------------------------------------------
package shift_reg_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_M = 5;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//
// Purpose: one N-bit register of the shift_reg delay line, with a
//          synchronous active-high clear.
//
// Ports:
//   Clk  in   1  clock; the register updates on the rising edge
//   Clr  in   1  synchronous clear; when high, q loads zero and d is ignored
//   d    in   N  next word for this stage
//   q    out  N  registered word
// -----------------------------------------------------------------------------
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // The register has no power-on value. Until the first clear, q holds
    // whatever the simulator or the device starts with.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule : shift_stage

// File: rtl/shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg
//
// Purpose: synchronous multi-bit shift register used as a fixed-latency
//          delay line. On every clock edge, the word on SI enters stage 0 and
//          every stage moves one place toward the output. SO presents the
//          oldest stage, so SO always equals the SI value from M edges earlier.
//
// Parameters:
//   N  word width in bits (N >= 1)
//   M  number of stages, which is also the delay in cycles (M >= 1)
//
// Ports:
//   Clk  in   1  clock; all state updates on the rising edge
//   Clr  in   1  synchronous active-high clear; flushes every stage to zero
//                and overrides the shift for that edge
//   SI   in   N  word written into stage 0
//   SO   out  N  oldest stage (temp[M-1]), taken straight from a register
//
// Storage is exposed as the unpacked array temp[0:M-1]. temp[0] is the newest
// word and temp[M-1] is the oldest. Benches can observe it hierarchically.
// -----------------------------------------------------------------------------
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int M = DEFAULT_M
) (
    input  logic         Clk,
    input  logic         Clr,
    input  logic [N-1:0] SI,
    output logic [N-1:0] SO
);

    logic [N-1:0] temp [0:M-1];

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_stage
            logic [N-1:0] stage_d;
            logic [N-1:0] stage_q;

            // Stage 0 is fed from the input port. Every later stage is fed
            // from its predecessor. The generate branch is decided at
            // elaboration, so M = 1 builds only the first branch.
            if (gi == 0) begin : g_head
                assign stage_d = SI;
            end else begin : g_body
                assign stage_d = temp[gi-1];
            end

            shift_stage #(
                .N (N)
            ) u_stage (
                .Clk (Clk),
                .Clr (Clr),
                .d   (stage_d),
                .q   (stage_q)
            );

            assign temp[gi] = stage_q;
        end
    endgenerate

    // The output taps the last register directly. No path runs from SI to
    // SO without passing through a register, even when M = 1.
    assign SO = temp[M-1];

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_reg
//
// Self-checking bench for shift_reg with three geometries run side by side:
//   dut_a  N=4, M=5  (default geometry)
//   dut_c  N=4, M=1  (single stage)
//   dut_b  N=8, M=3
//
// All three share the clock and the clear. The reference model keeps a queue
// holding the last M accepted words for each instance. The newest word is at
// the front. A clear replaces the queue with M zeros. Directed steps also
// compare against literal values worked out by hand.
// -----------------------------------------------------------------------------
module tb_shift_reg;

    localparam int NA = 4;
    localparam int MA = 5;
    localparam int NB = 8;
    localparam int MB = 3;
    localparam int NC = 4;
    localparam int MC = 1;

    logic          clk = 1'b0;
    logic          clr;
    logic [4:0]    si_wide;   // drives the 4-bit inputs; the upper bit is dropped
    logic [NB-1:0] si_b;
    logic [NA-1:0] so_a;
    logic [NB-1:0] so_b;
    logic [NC-1:0] so_c;

    always #5 clk = ~clk;

    shift_reg #(.N(NA), .M(MA)) dut_a (
        .Clk (clk),
        .Clr (clr),
        .SI  (si_wide[NA-1:0]),
        .SO  (so_a)
    );

    shift_reg #(.N(NB), .M(MB)) dut_b (
        .Clk (clk),
        .Clr (clr),
        .SI  (si_b),
        .SO  (so_b)
    );

    shift_reg #(.N(NC), .M(MC)) dut_c (
        .Clk (clk),
        .Clr (clr),
        .SI  (si_wide[NC-1:0]),
        .SO  (so_c)
    );

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Reference model: each queue holds the words in flight, newest first.
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] q_c [$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(inout logic [7:0] q [$], input int depth, input logic [7:0] word);
        if (clr) begin
            q = {};
            repeat (depth) q.push_back(8'h00);
        end else begin
            q.push_front(word);
            while (q.size() > depth) void'(q.pop_back());
        end
    endtask

    task automatic compare_all();
        check("so_a", {4'h0, so_a}, q_a[MA-1]);
        check("so_b", so_b, q_b[MB-1]);
        check("so_c", {4'h0, so_c}, q_c[MC-1]);
        for (int i = 0; i < MA; i++)
            check($sformatf("temp_a[%0d]", i), {4'h0, dut_a.temp[i]}, q_a[i]);
        for (int i = 0; i < MB; i++)
            check($sformatf("temp_b[%0d]", i), dut_b.temp[i], q_b[i]);
    endtask

    // One clock edge: update the models from the inputs presented at the
    // edge, then sample the outputs 1 ns later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        model_push(q_a, MA, {4'h0, si_wide[3:0]});
        model_push(q_b, MB, si_b);
        model_push(q_c, MC, {4'h0, si_wide[3:0]});
        #1;
        if (check_en) compare_all();
    endtask

    int fill_si [10] = '{15, 1, 2, 3, 4, 4, 4, 4, 4, 4};
    int fill_so [10] = '{0, 0, 0, 0, 15, 1, 2, 3, 4, 4};
    int fill_tmp [5] = '{4, 3, 2, 1, 15};

    initial begin
        clr     = 1'b0;
        si_wide = '0;
        si_b    = '0;
        #1;

        // Load arbitrary contents with no checking, because the state is undefined.
        for (int k = 0; k < 6; k++) begin
            si_wide = 5'($urandom);
            si_b    = 8'($urandom);
            tick();
        end

        // Clear: every stage reads zero after one edge.
        check_en = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clear_so_a", {4'h0, so_a}, 8'h00);
        check("clear_so_b", so_b, 8'h00);
        for (int i = 0; i < MA; i++)
            check($sformatf("clear_temp_a[%0d]", i), {4'h0, dut_a.temp[i]}, 8'h00);

        // Fill and delay. 8'hA5 goes into the N=8, M=3 instance on the first edge.
        for (int k = 0; k < 10; k++) begin
            si_wide = 5'(fill_si[k]);
            si_b    = (k == 0) ? 8'hA5 : 8'h00;
            tick();
            check($sformatf("fill_so_a[%0d]", k), {4'h0, so_a}, 8'(fill_so[k]));
            check($sformatf("fill_so_c[%0d]", k), {4'h0, so_c}, 8'(fill_si[k]));
            check($sformatf("fill_so_b[%0d]", k), so_b, (k == 2) ? 8'hA5 : 8'h00);
            if (k == 4) begin
                for (int i = 0; i < MA; i++)
                    check($sformatf("fill_temp_a[%0d]", i), {4'h0, dut_a.temp[i]}, 8'(fill_tmp[i]));
            end
        end

        // Truncation: 31 into a 4-bit input comes out as 15, five edges later.
        si_wide = 5'd31;
        tick();
        si_wide = 5'd0;
        repeat (4) tick();
        check("trunc_so_a", {4'h0, so_a}, 8'h0F);

        // Mid-stream clear flushes the words in flight. After it, 7 appears on the fifth edge.
        for (int k = 1; k <= 3; k++) begin
            si_wide = 5'(k);
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < MA; i++)
            check($sformatf("mid_temp_a[%0d]", i), {4'h0, dut_a.temp[i]}, 8'h00);
        si_wide = 5'd7;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("mid_so_a[%0d]", k), {4'h0, so_a}, (k < 5) ? 8'h00 : 8'h07);
        end

        // Steady state: hold 9, so SO reads 9 from the fifth edge onward.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        si_wide = 5'd9;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("steady_so_a[%0d]", k), {4'h0, so_a}, (k < 5) ? 8'h00 : 8'h09);
        end

        // Random traffic with occasional clears, checked against the models only.
        for (int k = 0; k < 80; k++) begin
            clr     = ($urandom_range(0, 9) == 0);
            si_wide = 5'($urandom);
            si_b    = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_shift_reg
